// File: rtl/mc_datapath.sv
// mc_datapath: parametrised multi-cycle datapath running the 3-bit-opcode
// rt/rs/imm instruction set through FETCH/DECODE/EXEC/MEM/WB. Instruction
// and data memories are external and use req/ack handshakes. HALT is sticky
// until reset.
//
// Ports
//   sysclk, sysrst_n          clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata   instruction fetch handshake, addr = pc
//   dmem_req/we/addr/wdata    data access request (we=1 store)
//   dmem_ack/rdata            data access completion, load data
//   halted                    core stopped in HALT
//   dbg_rsel/dbg_rdata        combinational debug register read
module mc_datapath #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned REG_BITS = 1,
    parameter int unsigned IMM_W    = 3,
    parameter int unsigned PC_W     = 8,
    localparam int unsigned INSTR_W = 3 + 2 * REG_BITS + IMM_W
) (
    input  logic                sysclk,
    input  logic                sysrst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                halted,
    input  logic [REG_BITS-1:0] dbg_rsel,
    output logic [DATA_W-1:0]   dbg_rdata
);

    localparam int unsigned NREG = 1 << REG_BITS;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [PC_W-1:0]       r_pc;
    logic [INSTR_W-1:0]    r_ir;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [DATA_W-1:0]     r_aluout;
    logic [DATA_W-1:0]     r_mdr;
    logic [DATA_W-1:0]     r_regs [NREG];

    logic                  r_imem_req;
    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic                  r_halted;

    logic                  w_imem_req_nxt;
    logic                  w_dmem_req_nxt;
    logic                  w_dmem_we_nxt;
    logic                  w_halted_nxt;

    logic [2:0]            w_op;
    logic [REG_BITS-1:0]   w_rt;
    logic [REG_BITS-1:0]   w_rs;
    logic [IMM_W-1:0]      w_imm;
    logic [DATA_W-1:0]     w_imm_d;
    logic [PC_W-1:0]       w_imm_pc;
    logic [DATA_W-1:0]     w_alu;
    logic                  w_iack;
    logic                  w_dack;

    // Instruction field decode and immediate sign extension
    assign w_op     = r_ir[INSTR_W-1 -: 3];
    assign w_rt     = r_ir[INSTR_W-4 -: REG_BITS];
    assign w_rs     = r_ir[IMM_W+REG_BITS-1 -: REG_BITS];
    assign w_imm    = r_ir[IMM_W-1:0];
    assign w_imm_d  = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_imm_pc = {{(PC_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};

    // Acks only count while the matching request is actually driven
    assign w_iack = r_imem_req & imem_ack;
    assign w_dack = r_dmem_req & dmem_ack;

    // ALU; memory ops use B + sext(imm) as the effective address
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:       w_alu = r_a + r_b;
            OP_SUB:       w_alu = r_a - r_b;
            OP_ADDI:      w_alu = r_a + w_imm_d;
            OP_NAND:      w_alu = ~(r_a & r_b);
            OP_LW, OP_SW: w_alu = r_b + w_imm_d;
            default:      w_alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_iack) w_next = S_DECODE;
            S_DECODE: w_next = (w_op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (w_op == OP_BEQ)                        w_next = S_FETCH;
                else if (w_op == OP_LW || w_op == OP_SW)   w_next = S_MEM;
                else                                       w_next = S_WB;
            end
            S_MEM:    if (w_dack) w_next = (w_op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output logic: next values of the registered handshake/status outputs
    always_comb begin
        w_imem_req_nxt = 1'b0;
        w_dmem_req_nxt = 1'b0;
        w_dmem_we_nxt  = 1'b0;
        w_halted_nxt   = 1'b0;
        case (w_next)
            S_FETCH: w_imem_req_nxt = 1'b1;
            S_MEM: begin
                w_dmem_req_nxt = 1'b1;
                w_dmem_we_nxt  = (w_op == OP_SW);
            end
            S_HALT:  w_halted_nxt = 1'b1;
            default: ;
        endcase
    end

    // Output registers; after reset the FETCH request rises on the first edge
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_imem_req <= w_imem_req_nxt;
            r_dmem_req <= w_dmem_req_nxt;
            r_dmem_we  <= w_dmem_we_nxt;
            r_halted   <= w_halted_nxt;
        end
    end

    // Datapath registers, register file written only in WB
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_iack) begin
                        r_ir <= imem_rdata;
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rt];
                    r_b <= r_regs[w_rs];
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                    // pc already points past the branch
                    if (w_op == OP_BEQ && r_a == r_b) begin
                        r_pc <= r_pc + w_imm_pc;
                    end
                end
                S_MEM: begin
                    if (w_dack && w_op == OP_LW) begin
                        r_mdr <= dmem_rdata;
                    end
                end
                S_WB: begin
                    r_regs[w_rt] <= (w_op == OP_LW) ? r_mdr : r_aluout;
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_aluout;
    assign dmem_wdata = r_a;
    assign halted     = r_halted;
    assign dbg_rdata  = r_regs[dbg_rsel];

endmodule
